// File: rtl/exe_pkg.sv
// exe_pkg: shared definitions for the execute stage.
//   - EXE_CMD encodings (exe_cmd_e)
//   - shifter type codes (shift_e)
//   - status register bit positions {N,Z,C,V}
//   - DATA_MEM_BASE default, used when DATA_MEM_OFFSET_EN is defined
//   - ror32 helper shared by the immediate and register shifters
package exe_pkg;

  typedef enum logic [3:0] {
    CMD_NOP = 4'b0000,
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } exe_cmd_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_e;

  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

  localparam logic [31:0] DATA_MEM_BASE_DEF = 32'd1024;

  // Rotate right; n=0 returns x (the left shift by 32 yields 0).
  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
    logic [5:0] lsh;
    lsh = 6'd32 - {1'b0, n};
    return (x >> n) | (x << lsh);
  endfunction

endpackage

// File: rtl/exe_alu.sv
// exe_alu: combinational ALU of the execute stage.
// Ports:
//   val1_i, val2_i  32  operands (Rn, generated second operand)
//   exe_cmd_i       4   operation code (exe_cmd_e)
//   c_i, v_i        1   carry / overflow from the decode-time status snapshot
//   res_o           32  result (0 for unknown codes)
//   nzcv_o          4   computed flags {N,Z,C,V}
//   flag_vld_o      1   low for unknown codes: status register must hold
module exe_alu
  import exe_pkg::*;
(
  input  logic [31:0] val1_i,
  input  logic [31:0] val2_i,
  input  logic [3:0]  exe_cmd_i,
  input  logic        c_i,
  input  logic        v_i,
  output logic [31:0] res_o,
  output logic [3:0]  nzcv_o,
  output logic        flag_vld_o
);

  logic [31:0] op_b;
  logic        cin;
  logic        arith;
  logic [32:0] sum;
  logic        ovf;

  always_comb begin
    op_b       = val2_i;
    cin        = 1'b0;
    arith      = 1'b0;
    flag_vld_o = 1'b1;
    res_o      = '0;
    // Subtract is Rn + ~Val2 + cin, so the adder carry-out is "no borrow".
    case (exe_cmd_e'(exe_cmd_i))
      CMD_SUB: begin op_b = ~val2_i; cin = 1'b1; arith = 1'b1; end
      CMD_SBC: begin op_b = ~val2_i; cin = c_i;  arith = 1'b1; end
      CMD_ADD: begin arith = 1'b1; end
      CMD_ADC: begin cin = c_i; arith = 1'b1; end
      default: ;
    endcase
    sum = {1'b0, val1_i} + {1'b0, op_b} + {32'd0, cin};
    // Overflow: operands of same sign give a result of the other sign.
    ovf = (val1_i[31] == op_b[31]) && (sum[31] != val1_i[31]);

    case (exe_cmd_e'(exe_cmd_i))
      CMD_MOV: res_o = val2_i;
      CMD_MVN: res_o = ~val2_i;
      CMD_ADD, CMD_ADC,
      CMD_SUB, CMD_SBC: res_o = sum[31:0];
      CMD_AND: res_o = val1_i & val2_i;
      CMD_ORR: res_o = val1_i | val2_i;
      CMD_EOR: res_o = val1_i ^ val2_i;
      default: flag_vld_o = 1'b0;
    endcase

    nzcv_o[SR_N] = res_o[31];
    nzcv_o[SR_Z] = (res_o == 32'd0);
    nzcv_o[SR_C] = arith ? sum[32] : c_i;
    nzcv_o[SR_V] = arith ? ovf     : v_i;
  end

endmodule

// File: rtl/exe_module.sv
// exe_module: execute stage of the five-stage ARM pipeline.
// Generates the second operand, runs exe_alu, computes the branch target,
// owns the NZCV status register and the EXE/MEM pipeline register.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   WB_EN_IN/MEM_R_EN_IN/MEM_W_EN_IN control bits from decode
//   B_IN, S_IN, SR_IN, EXE_CMD       branch, set-flags, status snapshot, op
//   PC_IN, Val_Rn, Val_Rm_IN         PC+4 and register operands
//   imm, Shift_operand, Signed_imm_24, Dest_IN
//   Branch_Taken, Branch_Address     combinational toward fetch
//   SR                               live status register to decode
//   WB_EN, MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, Dest  registered
// Build option: DATA_MEM_OFFSET_EN subtracts DATA_MEM_BASE from memory
// addresses (flags are never affected).
module exe_module
  import exe_pkg::*;
#(
  parameter logic [31:0] DATA_MEM_BASE = DATA_MEM_BASE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_EN_IN,
  input  logic        MEM_R_EN_IN,
  input  logic        MEM_W_EN_IN,
  input  logic        B_IN,
  input  logic        S_IN,
  input  logic [3:0]  SR_IN,
  input  logic [3:0]  EXE_CMD,
  input  logic [31:0] PC_IN,
  input  logic [31:0] Val_Rn,
  input  logic [31:0] Val_Rm_IN,
  input  logic        imm,
  input  logic [11:0] Shift_operand,
  input  logic [23:0] Signed_imm_24,
  input  logic [3:0]  Dest_IN,
  output logic        Branch_Taken,
  output logic [31:0] Branch_Address,
  output logic [3:0]  SR,
  output logic        WB_EN,
  output logic        MEM_R_EN,
  output logic        MEM_W_EN,
  output logic [31:0] ALU_Res,
  output logic [31:0] Val_Rm,
  output logic [3:0]  Dest
);

  logic [31:0] val2;
  logic [4:0]  sh_amt;
  logic        mem_op;
  logic [31:0] alu_res;
  logic [3:0]  alu_nzcv;
  logic        alu_flag_vld;

  logic [3:0]  sr_d,      sr_q;
  logic        wb_d,      wb_q;
  logic        mr_d,      mr_q;
  logic        mw_d,      mw_q;
  logic [31:0] res_d,     res_q;
  logic [31:0] rm_d,      rm_q;
  logic [3:0]  dest_d,    dest_q;

  assign mem_op = MEM_R_EN_IN | MEM_W_EN_IN;
  assign sh_amt = Shift_operand[11:7];

  // Second operand: memory offset beats immediate beats shifted register.
  always_comb begin
    val2 = Val_Rm_IN;
    if (mem_op) begin
      val2 = {{20{Shift_operand[11]}}, Shift_operand};
    end else if (imm) begin
      val2 = ror32({24'd0, Shift_operand[7:0]}, {Shift_operand[11:8], 1'b0});
    end else if (!Shift_operand[4]) begin
      case (shift_e'(Shift_operand[6:5]))
        SH_LSL: val2 = Val_Rm_IN << sh_amt;
        SH_LSR: val2 = Val_Rm_IN >> sh_amt;
        SH_ASR: val2 = $unsigned($signed(Val_Rm_IN) >>> sh_amt);
        SH_ROR: val2 = ror32(Val_Rm_IN, sh_amt);
        default: val2 = Val_Rm_IN;
      endcase
    end
    // Shift_operand[4]=1 (register-specified shift) is not supported: pass Rm.
  end

  exe_alu u_alu (
    .val1_i    (Val_Rn),
    .val2_i    (val2),
    .exe_cmd_i (EXE_CMD),
    .c_i       (SR_IN[SR_C]),
    .v_i       (SR_IN[SR_V]),
    .res_o     (alu_res),
    .nzcv_o    (alu_nzcv),
    .flag_vld_o(alu_flag_vld)
  );

  assign Branch_Taken   = B_IN;
  assign Branch_Address = PC_IN + {{6{Signed_imm_24[23]}}, Signed_imm_24, 2'b00};

  always_comb begin
    sr_d   = (S_IN && alu_flag_vld) ? alu_nzcv : sr_q;
    wb_d   = WB_EN_IN;
    mr_d   = MEM_R_EN_IN;
    mw_d   = MEM_W_EN_IN;
    rm_d   = Val_Rm_IN;
    dest_d = Dest_IN;
`ifdef DATA_MEM_OFFSET_EN
    res_d  = mem_op ? (alu_res - DATA_MEM_BASE) : alu_res;
`else
    res_d  = alu_res;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q   <= '0;
      wb_q   <= 1'b0;
      mr_q   <= 1'b0;
      mw_q   <= 1'b0;
      res_q  <= '0;
      rm_q   <= '0;
      dest_q <= '0;
    end else begin
      sr_q   <= sr_d;
      wb_q   <= wb_d;
      mr_q   <= mr_d;
      mw_q   <= mw_d;
      res_q  <= res_d;
      rm_q   <= rm_d;
      dest_q <= dest_d;
    end
  end

  assign SR       = sr_q;
  assign WB_EN    = wb_q;
  assign MEM_R_EN = mr_q;
  assign MEM_W_EN = mw_q;
  assign ALU_Res  = res_q;
  assign Val_Rm   = rm_q;
  assign Dest     = dest_q;

endmodule
